// File: rtl/adder_share_arbiter_if.sv
// rtl/adder_share_arbiter_if.sv - requester, shared-adder and response signals of adder_share_arbiter
// Macro ADDER_ARB_CARRY_EN adds rsp_carry.
interface adder_share_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 32,
    parameter int ID_W    = 2
);
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ*WIDTH-1:0] req_a;
    logic [NUM_REQ*WIDTH-1:0] req_b;
    logic [WIDTH-1:0]         add_a;
    logic [WIDTH-1:0]         add_b;
    logic [WIDTH-1:0]         add_s;
    logic                     rsp_valid;
    logic                     rsp_ready;
    logic [ID_W-1:0]          rsp_id;
    logic [WIDTH-1:0]         rsp_sum;
`ifdef ADDER_ARB_CARRY_EN
    logic                     rsp_carry;
`endif

    modport master (
        output req_valid, req_a, req_b, add_s, rsp_ready,
`ifdef ADDER_ARB_CARRY_EN
        input  rsp_carry,
`endif
        input  req_ready, add_a, add_b, rsp_valid, rsp_id, rsp_sum
    );

    modport slave (
        input  req_valid, req_a, req_b, add_s, rsp_ready,
`ifdef ADDER_ARB_CARRY_EN
        output rsp_carry,
`endif
        output req_ready, add_a, add_b, rsp_valid, rsp_id, rsp_sum
    );
endinterface

// File: rtl/adder_share_arbiter.sv
// rtl/adder_share_arbiter.sv - round-robin arbiter time-sharing one external combinational adder
// Macro ADDER_ARB_CARRY_EN registers the adder carry-out as rsp_carry.
module adder_share_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 32,
    parameter int ID_W    = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    adder_share_arbiter_if.slave bus
);
    typedef enum logic {IDLE, HOLD} state_t;

    state_t           state, state_nxt;
    logic [ID_W-1:0]  rr_ptr, ptr_nxt;
    logic [ID_W-1:0]  gnt_id;
    logic             gnt_vld;
    logic             can_accept;
    int               idx;
    logic [WIDTH-1:0] sum_q;
    logic [ID_W-1:0]  id_q;

    // Rotating search starting at rr_ptr; no grant while reset is held.
    always_comb begin
        gnt_vld    = 1'b0;
        gnt_id     = '0;
        idx        = 0;
        can_accept = (state == IDLE) || bus.rsp_ready;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(rr_ptr) + k) % NUM_REQ;
            if (!gnt_vld && can_accept && !rst && bus.req_valid[idx]) begin
                gnt_vld = 1'b1;
                gnt_id  = ID_W'(idx);
            end
        end
    end

    always_comb begin
        bus.req_ready = '0;
        if (gnt_vld) begin
            bus.req_ready[gnt_id] = 1'b1;
        end
    end

    // Operands stay at zero without a grant so the shared adder does not toggle.
    assign bus.add_a = gnt_vld ? bus.req_a[int'(gnt_id)*WIDTH +: WIDTH] : '0;
    assign bus.add_b = gnt_vld ? bus.req_b[int'(gnt_id)*WIDTH +: WIDTH] : '0;

    always_comb begin
        state_nxt = state;
        ptr_nxt   = rr_ptr;
        if (gnt_vld) begin
            state_nxt = HOLD;
            ptr_nxt   = (gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;
        end else if (state == HOLD && bus.rsp_ready) begin
            state_nxt = IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            rr_ptr <= '0;
        end else begin
            state  <= state_nxt;
            rr_ptr <= ptr_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q <= '0;
            id_q  <= '0;
        end else if (gnt_vld) begin
            sum_q <= bus.add_s;
            id_q  <= gnt_id;
        end
    end

`ifdef ADDER_ARB_CARRY_EN
    logic carry_d, carry_q;

    // Carry-out recovered from operand and sum MSBs of the external adder.
    assign carry_d = (bus.add_a[WIDTH-1] & bus.add_b[WIDTH-1]) |
                     ((bus.add_a[WIDTH-1] | bus.add_b[WIDTH-1]) & ~bus.add_s[WIDTH-1]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            carry_q <= 1'b0;
        end else if (gnt_vld) begin
            carry_q <= carry_d;
        end
    end

    assign bus.rsp_carry = carry_q;
`endif

    assign bus.rsp_valid = (state == HOLD);
    assign bus.rsp_sum   = sum_q;
    assign bus.rsp_id    = id_q;
endmodule

// File: tb/tb_adder_share_arbiter.sv
// tb/tb_adder_share_arbiter.sv - self-checking bench for adder_share_arbiter
// Macro ADDER_ARB_CARRY_EN also checks rsp_carry.
module tb_adder_share_arbiter;
    localparam int N   = 4;
    localparam int W   = 32;
    localparam int IDW = 2;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    logic [W-1:0] op_a [N];
    logic [W-1:0] op_b [N];
    logic [W-1:0] rr_sum [N];

    adder_share_arbiter_if #(.NUM_REQ(N), .WIDTH(W), .ID_W(IDW)) bus ();

    adder_share_arbiter #(.NUM_REQ(N), .WIDTH(W), .ID_W(IDW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    for (genvar i = 0; i < N; i++) begin : g_pack
        assign bus.req_a[i*W +: W] = op_a[i];
        assign bus.req_b[i*W +: W] = op_b[i];
    end

    // The external shared adder.
    assign bus.add_s = bus.add_a + bus.add_b;

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: pending response and pointer as of the next rising edge.
    bit           m_hold  = 1'b0;
    int           m_ptr   = 0;
    int           m_id    = 0;
    logic [W-1:0] m_sum   = '0;
    bit           m_carry = 1'b0;

    always @(posedge rst) begin
        m_hold  = 1'b0;
        m_ptr   = 0;
        m_id    = 0;
        m_sum   = '0;
        m_carry = 1'b0;
    end

    always @(negedge clk) begin : cmp
        int           g;
        logic [W-1:0] ea, eb;
        logic [W:0]   full;
        g  = -1;
        ea = '0;
        eb = '0;
        chk("model_rsp_valid", bus.rsp_valid, m_hold);
        chk("model_rsp_id", bus.rsp_id, m_id);
        chk("model_rsp_sum", bus.rsp_sum, m_sum);
`ifdef ADDER_ARB_CARRY_EN
        chk("model_rsp_carry", bus.rsp_carry, m_carry);
`endif
        if (!rst && (!m_hold || bus.rsp_ready)) begin
            for (int k = 0; k < N; k++) begin
                if (g < 0 && bus.req_valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
            end
        end
        if (g >= 0) begin
            ea = op_a[g];
            eb = op_b[g];
        end
        chk("model_req_ready", bus.req_ready, (g >= 0) ? (64'd1 << g) : 64'd0);
        chk("model_add_a", bus.add_a, ea);
        chk("model_add_b", bus.add_b, eb);
        if (g >= 0) begin
            full    = {1'b0, ea} + {1'b0, eb};
            m_sum   = full[W-1:0];
            m_carry = full[W];
            m_id    = g;
            m_hold  = 1'b1;
            m_ptr   = (g + 1) % N;
        end else if (m_hold && bus.rsp_ready) begin
            m_hold = 1'b0;
        end
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg;
        @(negedge clk);
        #1;
    endtask

    initial begin
        rst           = 1'b1;
        bus.req_valid = '1;
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < N; i++) begin
            op_a[i] = W'(32'h1000 * (i + 1));
            op_b[i] = W'(i);
        end
        rr_sum[0] = 32'h0000_1000;
        rr_sum[1] = 32'h0000_2001;
        rr_sum[2] = 32'h0000_3002;
        rr_sum[3] = 32'h0000_4003;

        // Reset state with requests already valid.
        repeat (2) @(posedge clk);
        at_neg;
        chk("reset_rsp_valid", bus.rsp_valid, 0);
        chk("reset_rsp_sum", bus.rsp_sum, 0);
        chk("reset_rsp_id", bus.rsp_id, 0);
        chk("reset_req_ready", bus.req_ready, 0);
        step;
        rst = 1'b0;

        // All four valid: one grant per cycle in order 0,1,2,3,0.
        at_neg;
        chk("rr_first_ready", bus.req_ready, 4'b0001);
        for (int i = 0; i < 5; i++) begin
            at_neg;
            chk("rr_rsp_valid", bus.rsp_valid, 1);
            chk("rr_rsp_id", bus.rsp_id, i % N);
            chk("rr_rsp_sum", bus.rsp_sum, rr_sum[i % N]);
        end
        step;
        bus.req_valid = '0;
        step;

        // Single request, pointer at 2.
        bus.req_valid = 4'b0001;
        op_a[0] = 32'h0000_1000;
        op_b[0] = 32'd4;
        at_neg;
        chk("single_ready", bus.req_ready, 4'b0001);
        chk("single_add_a", bus.add_a, 32'h0000_1000);
        chk("single_add_b", bus.add_b, 32'd4);
        step;
        bus.req_valid = '0;
        at_neg;
        chk("single_rsp_valid", bus.rsp_valid, 1);
        chk("single_rsp_id", bus.rsp_id, 0);
        chk("single_rsp_sum", bus.rsp_sum, 32'h0000_1004);
        step;

        // Idle: adder quiet, pointer untouched (stays 1).
        for (int i = 0; i < 10; i++) begin
            at_neg;
            chk("idle_add_a", bus.add_a, 0);
            chk("idle_add_b", bus.add_b, 0);
            chk("idle_rsp_valid", bus.rsp_valid, 0);
        end
        step;
        bus.req_valid = 4'b1011;
        at_neg;
        chk("idle_ptr_ready", bus.req_ready, 4'b0010);
        step;

        // Backpressure: requester 2 result held while requester 1 waits.
        bus.req_valid = 4'b0100;
        op_a[2] = 32'h0000_000A;
        op_b[2] = 32'h0000_0005;
        at_neg;
        chk("bp_prev_id", bus.rsp_id, 1);
        chk("bp_ready2", bus.req_ready, 4'b0100);
        step;
        bus.req_valid = 4'b0010;
        op_a[1] = 32'h0000_0020;
        op_b[1] = 32'h0000_0003;
        bus.rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            at_neg;
            chk("bp_hold_valid", bus.rsp_valid, 1);
            chk("bp_hold_id", bus.rsp_id, 2);
            chk("bp_hold_sum", bus.rsp_sum, 32'h0000_000F);
            chk("bp_hold_ready", bus.req_ready, 0);
            chk("bp_hold_add_a", bus.add_a, 0);
            step;
        end
        bus.rsp_ready = 1'b1;
        at_neg;
        chk("bp_release_ready", bus.req_ready, 4'b0010);
        chk("bp_release_id", bus.rsp_id, 2);
        step;
        bus.req_valid = '0;
        at_neg;
        chk("bp_next_id", bus.rsp_id, 1);
        chk("bp_next_sum", bus.rsp_sum, 32'h0000_0023);
        step;

        // Wrap-around and carry.
        bus.req_valid = 4'b1000;
        op_a[3] = 32'hFFFF_FFFF;
        op_b[3] = 32'd1;
        step;
        bus.req_valid = 4'b0001;
        op_a[0] = 32'h7FFF_FFFF;
        op_b[0] = 32'd1;
        at_neg;
        chk("wrap_id", bus.rsp_id, 3);
        chk("wrap_sum", bus.rsp_sum, 32'h0000_0000);
        chk("wrap_ready0", bus.req_ready, 4'b0001);
`ifdef ADDER_ARB_CARRY_EN
        chk("wrap_carry", bus.rsp_carry, 1);
`endif
        step;
        bus.req_valid = '0;
        bus.rsp_ready = 1'b0;
        at_neg;
        chk("msb_id", bus.rsp_id, 0);
        chk("msb_sum", bus.rsp_sum, 32'h8000_0000);
`ifdef ADDER_ARB_CARRY_EN
        chk("msb_carry", bus.rsp_carry, 0);
`endif

        // Asynchronous reset while holding a result.
        #1;
        rst = 1'b1;
        bus.req_valid = '1;
        #1;
        chk("arst_rsp_valid", bus.rsp_valid, 0);
        chk("arst_rsp_sum", bus.rsp_sum, 0);
        chk("arst_rsp_id", bus.rsp_id, 0);
        chk("arst_req_ready", bus.req_ready, 0);
        bus.rsp_ready = 1'b1;
        step;
        step;
        rst = 1'b0;
        at_neg;
        chk("post_rst_ready", bus.req_ready, 4'b0001);
        step;
        bus.req_valid = '0;
        at_neg;
        chk("post_rst_id", bus.rsp_id, 0);
        chk("post_rst_sum", bus.rsp_sum, 32'h8000_0000);
        step;
        step;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
